// File: rtl/layer_serializer.sv
// Serializes one layer's parallel neuron outputs into a gap-free burst for the next layer.
// One active frame is being sent while at most one more waits in the pending slot.
module layer_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int gapCycles  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            x_valid,
  input  logic [numNeurons*dataWidth-1:0] x_in,
  output logic [dataWidth-1:0]            data_out,
  output logic                            data_out_valid,
  output logic                            busy,
  output logic                            overrun
);

  localparam int IW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam int GW = $clog2(gapCycles + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(numNeurons - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(gapCycles);
  localparam logic [GW-1:0] GAP_LAST = GW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  logic [dataWidth-1:0] w_x_word [numNeurons];
  logic [dataWidth-1:0] r_active [numNeurons];
  logic [dataWidth-1:0] r_pending [numNeurons];

  state_t               r_state;
  logic                 r_pend_full;
  logic [IW-1:0]        r_idx;
  logic [GW-1:0]        r_gap;
  logic [dataWidth-1:0] r_data_out;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_overrun;

  logic                 w_take;
  logic                 w_cap_pend;
  logic                 w_drop;
  logic                 w_pend_next;
  logic [IW-1:0]        w_next_idx;

  for (genvar gi = 0; gi < numNeurons; gi++) begin : g_unpack
    assign w_x_word[gi] = x_in[gi*dataWidth +: dataWidth];
  end

  // Pending moves to active at the end of a gap, or one cycle later when it
  // was filled during the very last gap cycle (no IDLE shortcut).
  assign w_take      = r_pend_full &&
                       ((r_state == S_IDLE) || (r_state == S_GAP && r_gap == GAP_LAST));
  assign w_cap_pend  = x_valid && (r_state != S_IDLE || r_pend_full) &&
                       (!r_pend_full || w_take);
  assign w_drop      = x_valid && r_pend_full && !w_take;
  assign w_pend_next = w_cap_pend ? 1'b1 : (w_take ? 1'b0 : r_pend_full);
  assign w_next_idx  = r_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pend_full <= 1'b0;
      r_idx       <= '0;
      r_gap       <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_drop)
        r_overrun <= 1'b1;
      if (w_cap_pend)
        r_pending <= w_x_word;
      r_pend_full <= w_pend_next;

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_active   <= r_pending;
            r_idx      <= '0;
            r_data_out <= r_pending[0];
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end else if (x_valid) begin
            r_active   <= w_x_word;
            r_idx      <= '0;
            r_data_out <= w_x_word[0];
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end else begin
            r_busy <= w_pend_next;
          end
        end

        S_SEND: begin
          r_busy <= 1'b1;
          if (r_idx == LAST_IDX) begin
            r_gap      <= GAP_LOAD;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_state    <= S_GAP;
          end else begin
            r_idx      <= w_next_idx;
            r_data_out <= r_active[w_next_idx];
          end
        end

        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            if (w_take) begin
              r_active   <= r_pending;
              r_idx      <= '0;
              r_data_out <= r_pending[0];
              r_valid    <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_SEND;
            end else begin
              r_busy  <= w_pend_next;
              r_state <= S_IDLE;
            end
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_valid;
  assign busy           = r_busy;
  assign overrun        = r_overrun;

endmodule
